// File: rtl/audio_mixer_pkg.sv
// Shared definitions for the audio mixer: default widths, unity gain helper,
// FSM state type and an index-width helper.
package audio_mixer_pkg;

  localparam int unsigned DEF_NCH    = 4;
  localparam int unsigned DEF_IN_W   = 16;
  localparam int unsigned DEF_GAIN_W = 8;
  localparam int unsigned DEF_OUT_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC    = 2'd1,
    ST_MASTER = 2'd2,
    ST_SAT    = 2'd3
  } mix_state_e;

  // Unity gain for a given gain width: 2**(gw-1).
  function automatic int unsigned unity_gain(input int unsigned gw);
    return 1 << (gw - 1);
  endfunction

  // Width of a counter that indexes n channels (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_mixer_gain_mul.sv
// audio_gain_mul: signed sample times unsigned gain, rescaled so that
// gain 2**(GW-1) is unity. Arithmetic shift, floor behaviour.
//   x  in  W       signed sample
//   g  in  GW      unsigned gain
//   y  out W+GW+1  signed (x*{0,g}) >>> (GW-1)
module audio_gain_mul #(
  parameter int unsigned W  = 16,
  parameter int unsigned GW = 8
) (
  input  logic signed [W-1:0]  x,
  input  logic        [GW-1:0] g,
  output logic signed [W+GW:0] y
);

  logic signed [W+GW:0] xe;
  logic signed [W+GW:0] ge;
  logic signed [W+GW:0] p;

  always_comb begin
    xe = (W+GW+1)'(x);
    ge = $signed((W+GW+1)'(g));
    p  = xe * ge;
    y  = p >>> (GW - 1);
  end

endmodule

// File: rtl/audio_mixer.sv
// audio_mixer: N-channel stereo mixer with per-channel gain/mute, serial
// accumulation, master gain, saturation to IN_W+1 bits and left-aligned
// OUT_W output words.
//   clk, rst_n      clock, asynchronous active-low reset
//   next_sample     strobe that snapshots inputs and starts a mix
//   ch_left/right   packed signed samples, channel k at [k*IN_W +: IN_W]
//   ch_gain/mute    per-channel gain (both sides) and mute
//   master_gain     gain on the summed mix
//   clip_clear      clears the sticky flags
//   out_left/right  left-aligned mixed words, held between mixes
//   out_valid       one-cycle pulse on update
//   busy            state != IDLE
//   clip_l/r, overrun  sticky flags
module audio_mixer
  import audio_mixer_pkg::*;
#(
  parameter int unsigned NCH    = DEF_NCH,
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned GAIN_W = DEF_GAIN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     next_sample,
  input  logic [NCH*IN_W-1:0]      ch_left,
  input  logic [NCH*IN_W-1:0]      ch_right,
  input  logic [NCH*GAIN_W-1:0]    ch_gain,
  input  logic [NCH-1:0]           ch_mute,
  input  logic [GAIN_W-1:0]        master_gain,
  input  logic                     clip_clear,
  output logic [OUT_W-1:0]         out_left,
  output logic [OUT_W-1:0]         out_right,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     clip_l,
  output logic                     clip_r,
  output logic                     overrun
);

  localparam int unsigned ACC_W = IN_W + GAIN_W + $clog2(NCH) + 1;
  localparam int unsigned PW    = IN_W + GAIN_W + 1;
  localparam int unsigned MW    = ACC_W + GAIN_W + 1;
  localparam int unsigned SW    = IN_W + 1;
  localparam int unsigned IDX_W = idx_width(NCH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
  localparam logic signed [MW-1:0] SAT_MAX = {{(MW-IN_W){1'b0}}, {IN_W{1'b1}}};
  localparam logic signed [MW-1:0] SAT_MIN = {{(MW-IN_W){1'b1}}, {IN_W{1'b0}}};

  mix_state_e               state_q;
  logic [IDX_W-1:0]         idx_q;
  logic [NCH*IN_W-1:0]      left_q, right_q;
  logic [NCH*GAIN_W-1:0]    gain_q;
  logic [NCH-1:0]           mute_q;
  logic [GAIN_W-1:0]        mgain_q;
  logic signed [ACC_W-1:0]  acc_l_q, acc_r_q;
  logic [OUT_W-1:0]         out_l_q, out_r_q;
  logic                     valid_q, clip_l_q, clip_r_q, overrun_q;

  logic signed [IN_W-1:0]   sel_l, sel_r;
  logic [GAIN_W-1:0]        sel_g;
  logic                     sel_m;
  logic signed [PW-1:0]     prod_l, prod_r;
  logic signed [ACC_W-1:0]  acc_l_d, acc_r_d;
  logic signed [MW-1:0]     m_l, m_r;
  logic [SW-1:0]            clamp_l, clamp_r;
  logic                     sat_l, sat_r;
  logic [OUT_W-1:0]         out_l_d, out_r_d;

  // Channel mux over the snapshot, driven by idx.
  always_comb begin
    sel_l = '0;
    sel_r = '0;
    sel_g = '0;
    sel_m = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_l = left_q[k*IN_W +: IN_W];
        sel_r = right_q[k*IN_W +: IN_W];
        sel_g = gain_q[k*GAIN_W +: GAIN_W];
        sel_m = mute_q[k];
      end
    end
  end

  audio_gain_mul #(.W(IN_W), .GW(GAIN_W)) u_ch_l (.x(sel_l), .g(sel_g), .y(prod_l));
  audio_gain_mul #(.W(IN_W), .GW(GAIN_W)) u_ch_r (.x(sel_r), .g(sel_g), .y(prod_r));
  audio_gain_mul #(.W(ACC_W), .GW(GAIN_W)) u_mst_l (.x(acc_l_q), .g(mgain_q), .y(m_l));
  audio_gain_mul #(.W(ACC_W), .GW(GAIN_W)) u_mst_r (.x(acc_r_q), .g(mgain_q), .y(m_r));

  always_comb begin
    acc_l_d = acc_l_q + (sel_m ? '0 : ACC_W'(prod_l));
    acc_r_d = acc_r_q + (sel_m ? '0 : ACC_W'(prod_r));

    sat_l   = (m_l > SAT_MAX) || (m_l < SAT_MIN);
    sat_r   = (m_r > SAT_MAX) || (m_r < SAT_MIN);
    clamp_l = (m_l > SAT_MAX) ? SAT_MAX[SW-1:0] :
              (m_l < SAT_MIN) ? SAT_MIN[SW-1:0] : m_l[SW-1:0];
    clamp_r = (m_r > SAT_MAX) ? SAT_MAX[SW-1:0] :
              (m_r < SAT_MIN) ? SAT_MIN[SW-1:0] : m_r[SW-1:0];

    out_l_d = OUT_W'(clamp_l) << (OUT_W - SW);
    out_r_d = OUT_W'(clamp_r) << (OUT_W - SW);
  end

  // Master gain and clamp are evaluated combinationally from the MASTER
  // state and registered on its exit edge, so the outputs and the
  // out_valid pulse are visible for exactly the SAT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      left_q    <= '0;
      right_q   <= '0;
      gain_q    <= '0;
      mute_q    <= '0;
      mgain_q   <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      valid_q   <= 1'b0;
      clip_l_q  <= 1'b0;
      clip_r_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // Clears come first so a same-cycle set below takes precedence.
      if (clip_clear) begin
        clip_l_q  <= 1'b0;
        clip_r_q  <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (next_sample && (state_q != ST_IDLE)) overrun_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (next_sample) begin
            left_q  <= ch_left;
            right_q <= ch_right;
            gain_q  <= ch_gain;
            mute_q  <= ch_mute;
            mgain_q <= master_gain;
            acc_l_q <= '0;
            acc_r_q <= '0;
            idx_q   <= '0;
            state_q <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc_l_q <= acc_l_d;
          acc_r_q <= acc_r_d;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_q <= ST_MASTER;
        end
        ST_MASTER: begin
          out_l_q <= out_l_d;
          out_r_q <= out_r_d;
          valid_q <= 1'b1;
          if (sat_l) clip_l_q <= 1'b1;
          if (sat_r) clip_r_q <= 1'b1;
          state_q <= ST_SAT;
        end
        ST_SAT:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_left  = out_l_q;
  assign out_right = out_r_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign clip_l    = clip_l_q;
  assign clip_r    = clip_r_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer (NCH=4, IN_W=16, GAIN_W=8, OUT_W=24).
module tb_audio_mixer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        next_sample;
  logic [63:0] ch_left, ch_right;
  logic [31:0] ch_gain;
  logic [3:0]  ch_mute;
  logic [7:0]  master_gain;
  logic        clip_clear;
  logic [23:0] out_left, out_right;
  logic        out_valid, busy, clip_l, clip_r, overrun;

  audio_mixer #(.NCH(4), .IN_W(16), .GAIN_W(8), .OUT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .next_sample(next_sample),
    .ch_left(ch_left), .ch_right(ch_right), .ch_gain(ch_gain),
    .ch_mute(ch_mute), .master_gain(master_gain), .clip_clear(clip_clear),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .busy(busy), .clip_l(clip_l), .clip_r(clip_r), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] l;
    logic [63:0] r;
    logic [31:0] g;
    logic [3:0]  mute;
    logic [7:0]  mg;
    logic [23:0] el;
    logic [23:0] er;
    logic        cl;
    logic        cr;
  } vec_t;

  localparam logic [31:0] G1 = 32'h8080_8080;
  localparam int NVEC = 11;

  vec_t vecs [NVEC];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    ch_left     = v.l;
    ch_right    = v.r;
    ch_gain     = v.g;
    ch_mute     = v.mute;
    master_gain = v.mg;
  endtask

  task automatic pulse_clear();
    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
  endtask

  // Raise next_sample in the current cycle (T) and return the cycle offset
  // at which out_valid is first seen, or -1 if it never arrives.
  task automatic run_mix(output int lat);
    lat = -1;
    next_sample = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) next_sample = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, nvalid, first;

    vecs[0]  = '{64'h0000_0000_0000_1000, 64'h0, G1, 4'h0, 8'd128, 24'h080000, 24'h000000, 1'b0, 1'b0};
    vecs[1]  = '{64'h7FFF_7FFF_7FFF_7FFF, 64'h0000_0000_0800_0000, G1, 4'h0, 8'd128, 24'h7FFF80, 24'h040000, 1'b1, 1'b0};
    vecs[2]  = '{64'h0000_0000_7FFF_7FFF, 64'h8000_8000_8000_8000, G1, 4'h0, 8'd128, 24'h7FFF00, 24'h800000, 1'b0, 1'b1};
    vecs[3]  = '{64'h0000_0000_0000_4000, 64'h0000_0000_0000_2000, 32'h8080_8040, 4'h0, 8'd128, 24'h100000, 24'h080000, 1'b0, 1'b0};
    vecs[4]  = '{64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFFE, 32'h8080_8040, 4'h0, 8'd128, 24'hFFFF80, 24'hFFFF80, 1'b0, 1'b0};
    vecs[5]  = '{64'h0000_0000_0100_4000, 64'h0000_0000_0000_4000, G1, 4'b0001, 8'd128, 24'h008000, 24'h000000, 1'b0, 1'b0};
    vecs[6]  = '{64'h0000_0000_0000_4000, 64'h0000_0000_0000_1234, 32'h8080_8000, 4'h0, 8'd128, 24'h000000, 24'h000000, 1'b0, 1'b0};
    vecs[7]  = '{64'h0000_0000_0000_1000, 64'h0000_0000_0000_F000, G1, 4'h0, 8'd64, 24'h040000, 24'hFC0000, 1'b0, 1'b0};
    vecs[8]  = '{64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_8000, 32'h8080_80FF, 4'h0, 8'd128, 24'h7F7F00, 24'h808000, 1'b0, 1'b0};
    vecs[9]  = '{64'h0000_0000_0000_1000, 64'h0, G1, 4'h0, 8'd255, 24'h0FF000, 24'h000000, 1'b0, 1'b0};
    vecs[10] = '{64'h0000_0000_7FFF_7FFF, 64'h0000_0000_0000_0001, 32'h8080_FFFF, 4'h0, 8'd128, 24'h7FFF80, 24'h000080, 1'b1, 1'b0};

    rst_n = 1'b0; next_sample = 1'b0; clip_clear = 1'b0;
    ch_left = '0; ch_right = '0; ch_gain = G1; ch_mute = '0; master_gain = 8'd128;
    repeat (3) tick();
    check("reset out_left",  32'(out_left), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset busy",      32'(busy), 32'h0);
    check("reset flags",     {29'h0, clip_l, clip_r, overrun}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Table of single mixes.
    for (int i = 0; i < NVEC; i++) begin
      apply_vec(vecs[i]);
      pulse_clear();
      run_mix(lat);
      check($sformatf("v%0d latency", i),   32'(lat), 32'd6);
      check($sformatf("v%0d out_left", i),  32'(out_left), 32'(vecs[i].el));
      check($sformatf("v%0d out_right", i), 32'(out_right), 32'(vecs[i].er));
      check($sformatf("v%0d clip_l", i),    32'(clip_l), 32'(vecs[i].cl));
      check($sformatf("v%0d clip_r", i),    32'(clip_r), 32'(vecs[i].cr));
      tick();
      check($sformatf("v%0d valid pulse", i), 32'(out_valid), 32'h0);
      check($sformatf("v%0d idle", i),        32'(busy), 32'h0);
    end

    // Overrun: second strobe at T+2 is ignored.
    apply_vec(vecs[0]);
    pulse_clear();
    nvalid = 0; first = 0;
    next_sample = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) next_sample = 1'b0;
      if (k == 2) next_sample = 1'b1;
      if (k == 3) next_sample = 1'b0;
      if (out_valid) begin
        nvalid++;
        if (first == 0) first = k;
      end
    end
    check("ovr valid count", 32'(nvalid), 32'd1);
    check("ovr latency",     32'(first), 32'd6);
    check("ovr flag",        32'(overrun), 32'h1);
    check("ovr out_left",    32'(out_left), 32'h080000);
    pulse_clear();
    check("ovr cleared",     32'(overrun), 32'h0);

    // clip_clear in the same cycle as clip set and overrun set.
    apply_vec(vecs[1]);
    pulse_clear();
    next_sample = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) next_sample = 1'b0;
      if (k == 5) begin
        next_sample = 1'b1;
        clip_clear  = 1'b1;
      end
      if (k == 6) begin
        next_sample = 1'b0;
        clip_clear  = 1'b0;
        check("setwins valid",   32'(out_valid), 32'h1);
        check("setwins clip_l",  32'(clip_l), 32'h1);
        check("setwins overrun", 32'(overrun), 32'h1);
      end
    end
    pulse_clear();
    check("clear clip_l",  32'(clip_l), 32'h0);
    check("clear overrun", 32'(overrun), 32'h0);

    // Snapshot: inputs changed at T+1 do not affect the mix.
    apply_vec(vecs[0]);
    first = 0;
    next_sample = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) begin
        next_sample = 1'b0;
        ch_left = 64'h7FFF_7FFF_7FFF_7FFF;
        ch_gain = 32'hFFFF_FFFF;
      end
      if (out_valid && first == 0) first = k;
    end
    check("snap latency",  32'(first), 32'd6);
    check("snap out_left", 32'(out_left), 32'h080000);
    check("snap clip_l",   32'(clip_l), 32'h0);

    // Reset mid-mix aborts it.
    apply_vec(vecs[1]);
    next_sample = 1'b1;
    tick();
    next_sample = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("rst busy",      32'(busy), 32'h0);
    check("rst out_left",  32'(out_left), 32'h0);
    check("rst out_valid", 32'(out_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) nvalid++;
    end
    check("rst no valid", 32'(nvalid), 32'd0);
    apply_vec(vecs[0]);
    run_mix(lat);
    check("post-rst latency",  32'(lat), 32'd6);
    check("post-rst out_left", 32'(out_left), 32'h080000);

    // Back-to-back: second strobe at T+7.
    apply_vec(vecs[2]);
    pulse_clear();
    run_mix(lat);
    check("b2b1 latency",   32'(lat), 32'd6);
    check("b2b1 out_left",  32'(out_left), 32'h7FFF00);
    check("b2b1 out_right", 32'(out_right), 32'h800000);
    tick();
    check("b2b gap valid", 32'(out_valid), 32'h0);
    check("b2b gap busy",  32'(busy), 32'h0);
    apply_vec(vecs[7]);
    run_mix(lat);
    check("b2b2 latency",   32'(lat), 32'd6);
    check("b2b2 out_left",  32'(out_left), 32'h040000);
    check("b2b2 out_right", 32'(out_right), 32'hFC0000);
    check("b2b overrun",    32'(overrun), 32'h0);
    check("b2b clip_r",     32'(clip_r), 32'h1);
    check("b2b clip_l",     32'(clip_l), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
